miner_axis_ctrl: RTL and testbench
==================================

// Module: miner_axis_ctrl
// PURPOSE
//  Sequences the bitcoin miner core inside the AXI-stream mining IP. Collects a
//  20-word block header from the input stream, starts the miner, waits for
//  completion or timeout, then streams the 8-word result hash out. Sits between
//  the DMA-facing AXIS ports and the miner core.
// PARAMETERS
//  TIMEOUT_CYCLES  32'd100_000_000  miner cycles allowed after start; 0 = never time out
// PORTS
//  aclk              in   1    single clock, all logic rising-edge
//  aresetn           in   1    asynchronous, active-low reset
//  s_axis_tdata      in   32   header word
//  s_axis_tvalid     in   1    input word valid
//  s_axis_tready     out  1    input word accepted when tvalid&tready
//  s_axis_tlast      in   1    frame end marker
//  m_axis_tdata      out  32   result hash word
//  m_axis_tvalid     out  1    result word valid
//  m_axis_tready     in   1    downstream ready
//  m_axis_tlast      out  1    high on 8th result word
//  miner_start       out  1    one-cycle start pulse to miner
//  blk_version       out  32   header word 0
//  prev_blk_hash     out  256  header words 1..8, word 1+k -> bits [32k+31:32k]
//  merkle_root_hash  out  256  header words 9..16, same packing
//  blk_time          out  32   header word 17
//  blk_nbits         out  32   header word 18
//  blk_nonce         out  32   header word 19
//  miner_done        in   1    miner finished (sampled level)
//  miner_hash        in   256  miner result, valid while miner_done
//  miner_nonce       in   32   winning nonce, valid while miner_done
//  found_nonce       out  32   miner_nonce captured on done
//  frame_err         out  1    one-cycle pulse: early tlast
//  timeout_err       out  1    one-cycle pulse: miner timeout
// BEHAVIOUR
//  Reset: state COLLECT, word count 0, all header regs/found_nonce 0,
//   s_axis_tready 0 during reset then 1, all other outputs 0.
//  States: COLLECT -> START -> WAIT -> SEND -> COLLECT.
//  COLLECT: s_axis_tready=1. Each accepted beat writes word[cnt], cnt++.
//   tlast with cnt<19: frame_err pulse, cnt=0, stay COLLECT, header regs keep
//   partial data (not used). Beat with cnt==19 (tlast don't-care) -> START.
//  START: s_axis_tready=0; miner_start=1 for exactly this cycle; timer=0 -> WAIT.
//  WAIT: timer++ per cycle. miner_done=1: latch miner_hash and miner_nonce
//   (found_nonce) -> SEND. timer==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) and no
//   done: timeout_err pulse -> COLLECT, no output. Done and expiry same cycle:
//   done wins.
//  SEND: m_axis_tvalid=1, tdata = hash word idx (idx 0 = bits[31:0]);
//   advance idx on tvalid&tready; tlast=1 at idx 7; handshake on idx 7 -> COLLECT.
//   tdata/tlast held stable while tvalid&!tready (AXIS rule).
//  Header outputs stable from START until next COLLECT write.
//  Input-to-start latency: miner_start one cycle after 20th accepted beat.
//  First result beat valid one cycle after miner_done sampled high.
//  Counters: cnt 5-bit, idx 3-bit, timer 32-bit, no wrap in normal flow.
//  aresetn low in any state: immediate clear to reset values; in-flight output
//   frame is abandoned, no tlast emitted.
// STRUCTURE
//  Package miner_ctrl_pkg: state enum (COLLECT,START,WAIT,SEND), HDR_WORDS=20,
//   RES_WORDS=8, word index constants (IDX_VERSION=0, IDX_PREV=1, IDX_MERKLE=9,
//   IDX_TIME=17, IDX_NBITS=18, IDX_NONCE=19).
//  Sub-module miner_ctrl_result_ser: 256-bit load, 8x32 AXIS serializer with tlast.
// TESTING
//  1 Header version 02000000, prev 671D0E2F..00000000, merkle 2CD900FC..45F4992E,
//    time 74749054, nbits 747B1B18, nonce 43F740C0; model done after 50 cycles,
//    hash=256'h00..01..1F pattern, slave ready osc low2/high6 -> fields match, 8
//    beats LSW first, tlast only on 8th, found_nonce = model nonce.
//  2 tlast on 6th beat -> frame_err 1 cycle, no miner_start, next full 20-word
//    frame mines normally.
//  3 TIMEOUT_CYCLES=100, model never done -> timeout_err exactly 100 cycles
//    after miner_start, m_axis_tvalid never high, s_axis_tready=1 next cycle.
//  4 m_axis_tready held low 20 cycles mid-SEND -> tdata/tlast stable, no beat lost.
//  5 aresetn low during SEND beat 3 -> all outputs reset values, then new frame OK.
//  6 Two frames back-to-back, s_axis_tvalid always 1 -> s_axis_tready low
//    START..SEND, both result frames correct and in order.

Source files
------------

// File: rtl/miner_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : miner_ctrl_pkg
// Purpose  : Shared types and constants for the AXI-stream miner sequencer:
//            state encoding, header/result word counts and the word index
//            of every block-header field.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package miner_ctrl_pkg;

   localparam int HDR_WORDS   = 20;
   localparam int RES_WORDS   = 8;

   localparam int IDX_VERSION = 0;
   localparam int IDX_PREV    = 1;
   localparam int IDX_MERKLE  = 9;
   localparam int IDX_TIME    = 17;
   localparam int IDX_NBITS   = 18;
   localparam int IDX_NONCE   = 19;

   localparam logic [4:0] CNT_LAST = 5'(HDR_WORDS - 1);
   localparam logic [2:0] IDX_LAST = 3'(RES_WORDS - 1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_SEND    = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/miner_ctrl_result_ser.sv
`default_nettype none
// ============================================================================
// Module   : miner_ctrl_result_ser
// Purpose  : Captures a 256-bit result hash and streams it out as eight
//            32-bit AXIS beats, least-significant word first, tlast on the
//            eighth beat.
// Ports    : clk, rst_n             clock, async active-low reset
//            load, load_data        capture hash and start a new frame
//            m_axis_*               AXIS master (tdata/tvalid/tready/tlast)
//            frame_done             final beat handshaken this cycle
// Revision : 1.0  initial release
// ============================================================================
module miner_ctrl_result_ser
   import miner_ctrl_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [255:0] load_data,
   output logic [31:0]  m_axis_tdata,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic         frame_done
);

   logic [255:0] hash_q, hash_d;
   logic [2:0]   idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         hs;

   assign hs = valid_q & m_axis_tready;

   always_comb begin
      hash_d  = hash_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load) begin
         hash_d  = load_data;
         idx_d   = 3'd0;
         valid_d = 1'b1;
      end else if (hs) begin
         if (idx_q == IDX_LAST) begin
            idx_d   = 3'd0;
            valid_d = 1'b0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hash_q  <= '0;
         idx_q   <= 3'd0;
         valid_q <= 1'b0;
      end else begin
         hash_q  <= hash_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   // Data and tlast are decoded purely from registers, so they cannot move
   // while the beat is stalled.
   assign m_axis_tdata  = hash_q[{idx_q, 5'd0} +: 32];
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = valid_q & (idx_q == IDX_LAST);
   assign frame_done    = hs & (idx_q == IDX_LAST);

endmodule
`default_nettype wire

// File: rtl/miner_axis_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : miner_axis_ctrl
// Purpose  : Sequences the miner core: collects a 20-word block header from
//            the AXIS slave port, pulses miner_start, waits for miner_done or
//            timeout, then streams the 8-word result hash on the AXIS master.
// Ports    : aclk, aresetn          clock, async active-low reset
//            s_axis_*               header input stream
//            m_axis_*               result hash output stream
//            miner_start            one-cycle start pulse to the miner
//            blk_* / *_hash         header fields presented to the miner
//            miner_done/hash/nonce  miner completion interface
//            found_nonce            winning nonce captured on done
//            frame_err, timeout_err one-cycle error pulses
// Revision : 1.0  initial release
// ============================================================================
module miner_axis_ctrl
   import miner_ctrl_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
)(
   input  logic         aclk,
   input  logic         aresetn,
   input  logic [31:0]  s_axis_tdata,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic         s_axis_tlast,
   output logic [31:0]  m_axis_tdata,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast,
   output logic         miner_start,
   output logic [31:0]  blk_version,
   output logic [255:0] prev_blk_hash,
   output logic [255:0] merkle_root_hash,
   output logic [31:0]  blk_time,
   output logic [31:0]  blk_nbits,
   output logic [31:0]  blk_nonce,
   input  logic         miner_done,
   input  logic [255:0] miner_hash,
   input  logic [31:0]  miner_nonce,
   output logic [31:0]  found_nonce,
   output logic         frame_err,
   output logic         timeout_err
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] hdr_q [HDR_WORDS];
   logic [31:0] hdr_d [HDR_WORDS];
   logic [31:0] nonce_q, nonce_d;
   logic        tready_q, tready_d;
   logic        start_q, start_d;
   logic        ferr_q, ferr_d;

   logic        beat_in;
   logic        expire;
   logic        ser_load;
   logic        ser_done;
   logic        timeout_hit;

   assign beat_in = s_axis_tvalid & tready_q;
   assign expire  = (TIMEOUT_CYCLES != 32'd0) && (timer_q == TIMEOUT_CYCLES - 32'd1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      hdr_d       = hdr_q;
      nonce_d     = nonce_q;
      ferr_d      = 1'b0;
      ser_load    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_COLLECT: begin
            if (beat_in) begin
               hdr_d[cnt_q] = s_axis_tdata;
               if (cnt_q == CNT_LAST) begin
                  // The 20th word completes the header whatever tlast says.
                  cnt_d   = 5'd0;
                  state_d = ST_START;
               end else if (s_axis_tlast) begin
                  cnt_d  = 5'd0;
                  ferr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ST_START: begin
            timer_d = 32'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + 32'd1;
            // Completion is checked first so it wins over a coincident expiry.
            if (miner_done) begin
               ser_load = 1'b1;
               nonce_d  = miner_nonce;
               state_d  = ST_SEND;
            end else if (expire) begin
               timeout_hit = 1'b1;
               state_d     = ST_COLLECT;
            end
         end
         ST_SEND: begin
            if (ser_done) begin
               state_d = ST_COLLECT;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
      tready_d = (state_d == ST_COLLECT);
      start_d  = (state_d == ST_START);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_COLLECT;
         cnt_q    <= 5'd0;
         timer_q  <= 32'd0;
         hdr_q    <= '{default: '0};
         nonce_q  <= 32'd0;
         tready_q <= 1'b0;
         start_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
         hdr_q    <= hdr_d;
         nonce_q  <= nonce_d;
         tready_q <= tready_d;
         start_q  <= start_d;
         ferr_q   <= ferr_d;
      end
   end

   miner_ctrl_result_ser u_ser (
      .clk           (aclk),
      .rst_n         (aresetn),
      .load          (ser_load),
      .load_data     (miner_hash),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .frame_done    (ser_done)
   );

   genvar k;
   generate
      for (k = 0; k < 8; k++) begin : g_pack
         assign prev_blk_hash[32*k +: 32]    = hdr_q[IDX_PREV + k];
         assign merkle_root_hash[32*k +: 32] = hdr_q[IDX_MERKLE + k];
      end
   endgenerate

   assign blk_version   = hdr_q[IDX_VERSION];
   assign blk_time      = hdr_q[IDX_TIME];
   assign blk_nbits     = hdr_q[IDX_NBITS];
   assign blk_nonce     = hdr_q[IDX_NONCE];
   assign found_nonce   = nonce_q;
   assign s_axis_tready = tready_q;
   assign miner_start   = start_q;
   assign frame_err     = ferr_q;
   // Expiry is decided in the same cycle miner_done is sampled (done must be
   // able to veto it), so this pulse is decoded rather than registered.
   assign timeout_err   = timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_miner_axis_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_miner_axis_ctrl
// Purpose  : Self-checking bench for miner_axis_ctrl with a behavioural miner
//            model and scoreboard of header words, result hashes and timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_miner_axis_ctrl;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic [31:0]  s_axis_tdata = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic         s_axis_tlast = 1'b0;
   logic [31:0]  m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic         m_axis_tlast;
   logic         miner_start;
   logic [31:0]  blk_version;
   logic [255:0] prev_blk_hash;
   logic [255:0] merkle_root_hash;
   logic [31:0]  blk_time;
   logic [31:0]  blk_nbits;
   logic [31:0]  blk_nonce;
   logic         miner_done = 1'b0;
   logic [255:0] miner_hash = '0;
   logic [31:0]  miner_nonce = '0;
   logic [31:0]  found_nonce;
   logic         frame_err;
   logic         timeout_err;

   always #5 aclk = ~aclk;

   miner_axis_ctrl #(.TIMEOUT_CYCLES(32'd100)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .miner_start(miner_start), .blk_version(blk_version),
      .prev_blk_hash(prev_blk_hash), .merkle_root_hash(merkle_root_hash),
      .blk_time(blk_time), .blk_nbits(blk_nbits), .blk_nonce(blk_nonce),
      .miner_done(miner_done), .miner_hash(miner_hash), .miner_nonce(miner_nonce),
      .found_nonce(found_nonce), .frame_err(frame_err), .timeout_err(timeout_err)
   );

   typedef struct packed { logic last; logic [31:0] data; } beat_t;

   beat_t        in_q[$];
   beat_t        out_q[$];
   int           acc_cyc_q[$], start_q[$], ferr_q[$], tout_q[$], rise_q[$], end_q[$];
   logic [255:0] exp_hash_q[$];

   int total = 0, bad = 0, cyc = 0;
   int valid_mode, ready_mode, mdl_delay, mdl_done_at, stall_cnt, valid_cycles;
   bit use_pat, busy, expect_rdy, hold_valid, prev_valid, mdl_wait;
   logic [31:0] hold_data, last_nonce;
   logic        hold_last;

   logic [31:0] t1w [20] = '{
      32'h02000000,
      32'h671D0E2F, 32'h8E9C5B0F, 32'h1D5A4B3C, 32'hA1B2C3D4,
      32'h0F1E2D3C, 32'h55AA33CC, 32'h12345678, 32'h00000000,
      32'h2CD900FC, 32'h9A8B7C6D, 32'h13579BDF, 32'h2468ACE0,
      32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADC0DE, 32'h45F4992E,
      32'h74749054, 32'h747B1B18, 32'h43F740C0};

   function automatic logic [255:0] make_hash(input bit pat);
      logic [255:0] h;
      for (int b = 0; b < 32; b++) h[8*(31-b) +: 8] = pat ? 8'(b) : 8'($urandom);
      return h;
   endfunction

   task automatic gen_frame(output logic [31:0] w [20]);
      for (int i = 0; i < 20; i++) w[i] = $urandom;
   endtask

   task automatic push_words(input logic [31:0] w [20], input int n, input int last_at);
      for (int i = 0; i < n; i++) in_q.push_back({(i == last_at), w[i]});
   endtask

   task automatic clear_logs();
      in_q.delete(); out_q.delete(); acc_cyc_q.delete(); start_q.delete();
      ferr_q.delete(); tout_q.delete(); rise_q.delete(); end_q.delete();
      exp_hash_q.delete();
      valid_cycles = 0; stall_cnt = 0; mdl_wait = 0;
   endtask

   // Cycle engine: drives inputs on the falling edge, observes 1 ns later.
   // A tvalid&tready seen here is the handshake of the next rising edge.
   task automatic run(input int ncyc, input int want_beats, output bit reached);
      logic [255:0] h;
      reached = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge aclk);
         cyc++;
         if (in_q.size() > 0 && (valid_mode == 0 || $urandom_range(3) != 0)) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = in_q[0].data; s_axis_tlast = in_q[0].last;
         end else begin
            s_axis_tvalid = 1'b0; s_axis_tdata = $urandom; s_axis_tlast = 1'($urandom_range(1));
         end
         case (ready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ((cyc % 8) >= 2);
            2: m_axis_tready = 1'($urandom_range(1));
            default: begin
               if (out_q.size() == 3 && stall_cnt < 20) begin
                  m_axis_tready = 1'b0; stall_cnt++;
               end else m_axis_tready = 1'b1;
            end
         endcase
         miner_done = mdl_wait && (mdl_delay >= 0) && (cyc >= mdl_done_at);
         #1;
         if (expect_rdy) begin
            total++;
            if (s_axis_tready !== 1'b1) begin
               bad++; $display("FAIL rdy_after_frame cyc=%0d got=%b want=1", cyc, s_axis_tready);
            end
            expect_rdy = 0;
         end
         if (busy) begin
            total++;
            if (s_axis_tready !== 1'b0) begin
               bad++; $display("FAIL rdy_while_busy cyc=%0d got=%b want=0", cyc, s_axis_tready);
            end
         end
         if (hold_valid) begin
            total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_data || m_axis_tlast !== hold_last) begin
               bad++;
               $display("FAIL stall_stable cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                        cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_data, hold_last);
            end
         end
         hold_valid = m_axis_tvalid && !m_axis_tready;
         hold_data  = m_axis_tdata;
         hold_last  = m_axis_tlast;
         if (m_axis_tvalid && !prev_valid) rise_q.push_back(cyc);
         prev_valid = m_axis_tvalid;
         if (m_axis_tvalid) valid_cycles++;
         if (s_axis_tvalid && s_axis_tready) begin
            acc_cyc_q.push_back(cyc);
            void'(in_q.pop_front());
         end
         if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back({m_axis_tlast, m_axis_tdata});
            if (m_axis_tlast) begin busy = 0; expect_rdy = 1; end_q.push_back(cyc); end
         end
         if (miner_start) begin
            start_q.push_back(cyc);
            busy = 1; mdl_wait = 1; mdl_done_at = cyc + mdl_delay;
            h = make_hash(use_pat);
            miner_hash = h;
            miner_nonce = $urandom;
            last_nonce = miner_nonce;
            if (mdl_delay >= 0) exp_hash_q.push_back(h);
         end
         if (frame_err) ferr_q.push_back(cyc);
         if (timeout_err) begin tout_q.push_back(cyc); busy = 0; expect_rdy = 1; end
         if (want_beats > 0 && out_q.size() >= want_beats && in_q.size() == 0) begin
            reached = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge aclk);
      #1;
      total++;
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || miner_start !== 1'b0 ||
          frame_err !== 1'b0 || timeout_err !== 1'b0 || m_axis_tlast !== 1'b0) begin
         bad++; $display("FAIL reset_ctrl got rdy=%b v=%b st=%b fe=%b te=%b l=%b want all 0",
                         s_axis_tready, m_axis_tvalid, miner_start, frame_err, timeout_err, m_axis_tlast);
      end
      total++;
      if (blk_version !== 32'd0 || prev_blk_hash !== 256'd0 || merkle_root_hash !== 256'd0 ||
          blk_time !== 32'd0 || blk_nbits !== 32'd0 || blk_nonce !== 32'd0 ||
          found_nonce !== 32'd0 || m_axis_tdata !== 32'd0) begin
         bad++; $display("FAIL reset_regs got ver=%h nonce=%h fn=%h want 0", blk_version, blk_nonce, found_nonce);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      #1;
      total++;
      if (s_axis_tready !== 1'b1) begin
         bad++; $display("FAIL rdy_after_reset got=%b want=1", s_axis_tready);
      end
   endtask

   task automatic test_header_result();
      bit ok;
      logic [255:0] ep, em;
      clear_logs(); ready_mode = 1; valid_mode = 0; mdl_delay = 50; use_pat = 1;
      push_words(t1w, 20, 19);
      run(500, 8, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL t1_complete got beats=%0d want 8", out_q.size()); end
      total++;
      if (start_q.size() != 1 || acc_cyc_q.size() != 20 || start_q[0] != acc_cyc_q[19] + 1) begin
         bad++; $display("FAIL t1_start_latency got starts=%0d acc=%0d", start_q.size(), acc_cyc_q.size());
      end
      total++;
      if (rise_q.size() != 1 || start_q.size() != 1 || rise_q[0] != start_q[0] + 51) begin
         bad++; $display("FAIL t1_result_latency got rises=%0d want first beat 51 cycles after start", rise_q.size());
      end
      for (int k = 0; k < 8; k++) begin ep[32*k +: 32] = t1w[1+k]; em[32*k +: 32] = t1w[9+k]; end
      total++;
      if (blk_version !== t1w[0] || prev_blk_hash !== ep || merkle_root_hash !== em) begin
         bad++; $display("FAIL t1_fields_a got ver=%h prev=%h merkle=%h want ver=%h prev=%h merkle=%h",
                         blk_version, prev_blk_hash, merkle_root_hash, t1w[0], ep, em);
      end
      total++;
      if (blk_time !== t1w[17] || blk_nbits !== t1w[18] || blk_nonce !== t1w[19]) begin
         bad++; $display("FAIL t1_fields_b got %h %h %h want %h %h %h",
                         blk_time, blk_nbits, blk_nonce, t1w[17], t1w[18], t1w[19]);
      end
      for (int k = 0; k < 8 && k < out_q.size(); k++) begin
         total++;
         if (out_q[k] !== {(k == 7), exp_hash_q[0][32*k +: 32]}) begin
            bad++; $display("FAIL t1_beat%0d got %h want %h", k, out_q[k], {(k == 7), exp_hash_q[0][32*k +: 32]});
         end
      end
      total++;
      if (exp_hash_q[0][31:0] !== 32'h1C1D1E1F || found_nonce !== last_nonce) begin
         bad++; $display("FAIL t1_nonce got fn=%h want %h", found_nonce, last_nonce);
      end
   endtask

   task automatic test_frame_err();
      bit ok;
      logic [31:0] w [20];
      clear_logs(); ready_mode = 2; valid_mode = 1; mdl_delay = 5 + int'($urandom_range(35)); use_pat = 0;
      gen_frame(w); push_words(w, 6, 5);
      gen_frame(w); push_words(w, 20, 19);
      run(800, 8, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL t2_complete got beats=%0d want 8", out_q.size()); end
      total++;
      if (ferr_q.size() != 1 || acc_cyc_q.size() != 26 || ferr_q[0] != acc_cyc_q[5] + 1) begin
         bad++; $display("FAIL t2_frame_err got pulses=%0d want 1 right after beat 6", ferr_q.size());
      end
      total++;
      if (start_q.size() != 1 || acc_cyc_q.size() != 26 || start_q[0] != acc_cyc_q[25] + 1) begin
         bad++; $display("FAIL t2_start got starts=%0d want 1 after 26th beat", start_q.size());
      end
      total++;
      if (blk_version !== w[0] || blk_nonce !== w[19] || merkle_root_hash[255:224] !== w[16]) begin
         bad++; $display("FAIL t2_fields got ver=%h nonce=%h want %h %h", blk_version, blk_nonce, w[0], w[19]);
      end
      for (int k = 0; k < 8 && k < out_q.size(); k++) begin
         total++;
         if (out_q[k] !== {(k == 7), exp_hash_q[0][32*k +: 32]}) begin
            bad++; $display("FAIL t2_beat%0d got %h want %h", k, out_q[k], {(k == 7), exp_hash_q[0][32*k +: 32]});
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      logic [31:0] w [20];
      clear_logs(); ready_mode = 0; valid_mode = 0; mdl_delay = -1; use_pat = 0;
      gen_frame(w); push_words(w, 20, 19);
      run(200, 0, ok);
      total++;
      if (start_q.size() != 1 || tout_q.size() != 1 || tout_q[0] != start_q[0] + 100) begin
         bad++; $display("FAIL t3_timeout got starts=%0d pulses=%0d want 1 pulse 100 cycles after start",
                         start_q.size(), tout_q.size());
      end
      total++;
      if (valid_cycles != 0 || out_q.size() != 0) begin
         bad++; $display("FAIL t3_no_output got valid_cycles=%0d want 0", valid_cycles);
      end
   endtask

   task automatic test_stall();
      bit ok;
      logic [31:0] w [20];
      int nlast;
      clear_logs(); ready_mode = 3; valid_mode = 1; mdl_delay = 10; use_pat = 0;
      gen_frame(w); push_words(w, 20, 19);
      run(400, 8, ok);
      total++;
      if (!ok || stall_cnt != 20) begin
         bad++; $display("FAIL t4_stall got beats=%0d stall=%0d want 8 and 20", out_q.size(), stall_cnt);
      end
      nlast = 0;
      for (int k = 0; k < 8 && k < out_q.size(); k++) begin
         if (out_q[k].last) nlast++;
         total++;
         if (out_q[k].data !== exp_hash_q[0][32*k +: 32]) begin
            bad++; $display("FAIL t4_beat%0d got %h want %h", k, out_q[k].data, exp_hash_q[0][32*k +: 32]);
         end
      end
      total++;
      if (nlast != 1 || out_q.size() != 8 || !out_q[7].last) begin
         bad++; $display("FAIL t4_tlast got count=%0d want 1 on beat 8", nlast);
      end
   endtask

   task automatic test_reset_mid_send();
      bit ok;
      logic [31:0] w [20];
      clear_logs(); ready_mode = 0; valid_mode = 0; mdl_delay = 8; use_pat = 0;
      gen_frame(w); push_words(w, 20, 19);
      run(300, 3, ok);
      total++;
      if (!ok || out_q.size() != 3 || out_q[0].last || out_q[1].last || out_q[2].last) begin
         bad++; $display("FAIL t5_partial got beats=%0d want 3 without tlast", out_q.size());
      end
      @(posedge aclk);
      @(negedge aclk);
      #1;
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_hash_q[0][127:96]) begin
         bad++; $display("FAIL t5_beat3 got v=%b d=%h want 1 %h", m_axis_tvalid, m_axis_tdata, exp_hash_q[0][127:96]);
      end
      aresetn = 1'b0;
      #1;
      total++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 ||
          s_axis_tready !== 1'b0 || miner_start !== 1'b0 || found_nonce !== 32'd0 ||
          blk_version !== 32'd0 || blk_nonce !== 32'd0) begin
         bad++; $display("FAIL t5_reset got v=%b l=%b d=%h rdy=%b fn=%h ver=%h want all 0",
                         m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, found_nonce, blk_version);
      end
      busy = 0; expect_rdy = 0; hold_valid = 0; prev_valid = 0;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      clear_logs(); mdl_delay = 20; ready_mode = 2;
      gen_frame(w); push_words(w, 20, 19);
      run(400, 8, ok);
      total++;
      if (!ok || found_nonce !== last_nonce || blk_nonce !== w[19]) begin
         bad++; $display("FAIL t5_after got beats=%0d fn=%h want 8 %h", out_q.size(), found_nonce, last_nonce);
      end
      for (int k = 0; k < 8 && k < out_q.size(); k++) begin
         total++;
         if (out_q[k] !== {(k == 7), exp_hash_q[0][32*k +: 32]}) begin
            bad++; $display("FAIL t5_beat%0d got %h want %h", k, out_q[k], {(k == 7), exp_hash_q[0][32*k +: 32]});
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [31:0] w [20];
      clear_logs(); ready_mode = 2; valid_mode = 0; mdl_delay = 30; use_pat = 0;
      gen_frame(w); push_words(w, 20, 19);
      gen_frame(w); push_words(w, 20, 19);
      run(1000, 16, ok);
      total++;
      if (!ok || start_q.size() != 2 || exp_hash_q.size() != 2) begin
         bad++; $display("FAIL t6_complete got beats=%0d starts=%0d want 16 2", out_q.size(), start_q.size());
      end
      total++;
      if (acc_cyc_q.size() != 40 || end_q.size() < 1 || acc_cyc_q[20] != end_q[0] + 1 ||
          start_q.size() != 2 || start_q[1] != acc_cyc_q[39] + 1) begin
         bad++; $display("FAIL t6_timing got acc=%0d ends=%0d want second frame right after first result",
                         acc_cyc_q.size(), end_q.size());
      end
      for (int k = 0; k < 16 && k < out_q.size() && exp_hash_q.size() == 2; k++) begin
         total++;
         if (out_q[k] !== {((k % 8) == 7), exp_hash_q[k/8][32*(k%8) +: 32]}) begin
            bad++; $display("FAIL t6_beat%0d got %h want %h", k, out_q[k], {((k % 8) == 7), exp_hash_q[k/8][32*(k%8) +: 32]});
         end
      end
      total++;
      if (found_nonce !== last_nonce || blk_nonce !== w[19] || blk_version !== w[0]) begin
         bad++; $display("FAIL t6_fields got fn=%h nonce=%h want %h %h", found_nonce, blk_nonce, last_nonce, w[19]);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_header_result();
      test_frame_err();
      test_timeout();
      test_stall();
      test_reset_mid_send();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
